// File: rtl/two_four_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : two_four_decoder_if
//  Description : Handshake and output bundle for the registered 2-to-4
//                decoder. The master side supplies the enable, the 2-bit code
//                {a,b} and in_valid. The slave side (the decoder) returns
//                in_ready, the one-hot word y, out_valid and busy.
//  Signals     : en        decoder enable (low = abort, refuse input)
//                in_valid  code {a,b} is valid
//                in_ready  decoder can take a code this cycle
//                a, b      code MSB, LSB
//                y[3:0]    one-hot decode {s,r,q,p}
//                out_valid y holds a live decoded word
//                busy      decoder is holding a word
//  Revision    : 1.0 - initial release
// ============================================================================
interface two_four_decoder_if;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic       a;
    logic       b;
    logic [3:0] y;
    logic       out_valid;
    logic       busy;

    modport master (
        output en, in_valid, a, b,
        input  in_ready, y, out_valid, busy
    );

    modport slave (
        input  en, in_valid, a, b,
        output in_ready, y, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/two_four_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : two_four_decoder
//  Description : Registered 2-to-4 decoder. A 2-bit code {a,b} is accepted
//                through a valid/ready handshake. The matching one-hot word
//                y = {s,r,q,p} is then held for HOLD_CYCLES clocks. A new code
//                can be taken on the last hold cycle, so that back-to-back
//                words have no idle gap.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    two_four_decoder_if.slave (en, in_valid, in_ready,
//                       a, b, y, out_valid, busy)
//  Parameters  : HOLD_CYCLES  cycles each word is held (1..255)
//                CNT_W        hold-counter width (HOLD_CYCLES <= 2**CNT_W-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module two_four_decoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    two_four_decoder_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_reload  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_y;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_in_ready;
    logic             w_accept;
    logic [3:0]       w_code_y;

    // Ready is gated with rst_n so that it reads low for the whole reset
    // interval, even though the state already shows IDLE.
    always_comb begin
        w_in_ready = rst_n & bus.en &
                     ((r_state == S_IDLE) |
                      ((r_state == S_HOLD) & (r_cnt == '0)));
        w_accept   = bus.in_valid & w_in_ready;
        w_code_y   = 4'b0001 << {bus.a, bus.b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_y         <= 4'b0000;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_HOLD;
                        r_y         <= w_code_y;
                        r_cnt       <= c_reload;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!bus.en) begin
                        // Abort: the held word is dropped at once.
                        r_state     <= S_IDLE;
                        r_y         <= 4'b0000;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else if (w_accept) begin
                        // Last hold cycle with a new code: reload without a gap.
                        r_y   <= w_code_y;
                        r_cnt <= c_reload;
                    end else begin
                        r_state     <= S_IDLE;
                        r_y         <= 4'b0000;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_y         <= 4'b0000;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.y         = r_y;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire
